// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: FSM state encoding and
// sizing helpers for the iteration counter.
package restoring_divider_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_e;

    localparam int DIV_WIDTH = 8;

    // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/restoring_divider_subtraction_unit.sv
// Combinational ripple-borrow subtractor: diff = a - b, borrow_out set when a < b.
// Each stage is the borrow-form dual of a full adder.
module subtraction_unit #(
    parameter int WIDTH = 9
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    logic [WIDTH:0] borrow_s;

    assign borrow_s[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign diff[i]         = a[i] ^ b[i] ^ borrow_s[i];
        assign borrow_s[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & borrow_s[i]);
    end

    assign borrow_out = borrow_s[WIDTH];

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock,
// with a start/done handshake and results held until the next accepted request.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = cnt_width(WIDTH);

    div_state_e       state_r, state_nxt_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] dq_r, dq_nxt_s;
    logic [WIDTH-1:0] dvs_r, dvs_nxt_s;
    logic [WIDTH:0]   pr_r, pr_nxt_s;
    logic [2*WIDTH:0] shift_s;
    logic [WIDTH:0]   trial_s;
    logic             borrow_s;
    logic             res_load_s;
    logic             res_zero_s;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] quotient_r;
    logic [WIDTH-1:0] remainder_r;
    logic             div_by_zero_r;

    // The top bit of pr is shifted out; it is provably zero after every iteration.
    assign shift_s = {pr_r, dq_r} << 1;

    subtraction_unit #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a          (shift_s[2*WIDTH:WIDTH]),
        .b          ({1'b0, dvs_r}),
        .diff       (trial_s),
        .borrow_out (borrow_s)
    );

    // Next-state, datapath update and result-load decode.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        dq_nxt_s    = dq_r;
        dvs_nxt_s   = dvs_r;
        pr_nxt_s    = pr_r;
        res_load_s  = 1'b0;
        res_zero_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    dq_nxt_s  = dividend;
                    dvs_nxt_s = divisor;
                    pr_nxt_s  = {(WIDTH + 1){1'b0}};
                    cnt_nxt_s = CNT_W'(WIDTH);
                    if (divisor == {WIDTH{1'b0}}) begin
                        state_nxt_s = DONE;
                        res_load_s  = 1'b1;
                        res_zero_s  = 1'b1;
                    end else begin
                        state_nxt_s = RUN;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (borrow_s) begin
                    pr_nxt_s = shift_s[2*WIDTH:WIDTH];
                end else begin
                    pr_nxt_s = trial_s;
                end
                dq_nxt_s  = shift_s[WIDTH-1:0] | {{(WIDTH - 1){1'b0}}, ~borrow_s};
                cnt_nxt_s = cnt_r - CNT_W'(1);
                if (cnt_r == CNT_W'(1)) begin
                    state_nxt_s = DONE;
                    res_load_s  = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, iteration datapath and handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            dq_r    <= {WIDTH{1'b0}};
            dvs_r   <= {WIDTH{1'b0}};
            pr_r    <= {(WIDTH + 1){1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            dq_r    <= dq_nxt_s;
            dvs_r   <= dvs_nxt_s;
            pr_r    <= pr_nxt_s;
            busy_r  <= (state_nxt_s == RUN);
            done_r  <= (state_nxt_s == DONE);
        end
    end

    // Result registers, written only on entry to DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient_r    <= {WIDTH{1'b0}};
            remainder_r   <= {WIDTH{1'b0}};
            div_by_zero_r <= 1'b0;
        end else if (res_load_s) begin
            if (res_zero_s) begin
                quotient_r    <= {WIDTH{1'b1}};
                remainder_r   <= dividend;
                div_by_zero_r <= 1'b1;
            end else begin
                quotient_r    <= dq_nxt_s;
                remainder_r   <= pr_nxt_s[WIDTH-1:0];
                div_by_zero_r <= 1'b0;
            end
        end else begin
            quotient_r    <= quotient_r;
            remainder_r   <= remainder_r;
            div_by_zero_r <= div_by_zero_r;
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign quotient    = quotient_r;
    assign remainder   = remainder_r;
    assign div_by_zero = div_by_zero_r;

endmodule
